alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit_pkg.sv | 29 ++
 rtl/alu_exec_unit_if.sv | 33 +++
 rtl/alu_serial_shifter.sv | 42 ++++
 rtl/alu_exec_unit.sv | 130 +++++++++++++
 tb/tb_alu_exec_unit.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg
// Shared definitions for the ALU control decoder and the execute unit:
// ALU operation codes, the execute-unit FSM state encoding and a helper
// that tells whether an op code is in the supported set.
package alu_exec_unit_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_SLT, ALU_NOR, ALU_SLL: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if
// Request/result bundle of the ALU execute unit.
//   request : in_valid, in_ready, op_code, src_a, src_b, shamt
//   result  : out_valid, out_ready, result, zero, overflow, illegal_op
// master = requester/consumer side, slave = the execute unit.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [4:0]       shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal_op;

  modport master (
    output in_valid, op_code, src_a, src_b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal_op
  );

  modport slave (
    input  in_valid, op_code, src_a, src_b, shamt, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal_op
  );

endinterface

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter
// Serial left shifter: shifts one bit per clock under a 5-bit down-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture data_in and amount (takes priority over shifting)
//   data_in    : value to shift
//   amount     : number of single-bit shifts to perform
//   data       : current shift register contents
//   done       : the shift on the coming edge is the last one
module alu_serial_shifter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic [4:0]       amount,
  output logic [WIDTH-1:0] data,
  output logic             done
);

  logic [WIDTH-1:0] data_q;
  logic [4:0]       count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
    end else if (load) begin
      data_q  <= data_in;
      count_q <= amount;
    end else if (count_q != 5'd0) begin
      data_q  <= data_q << 1;
      count_q <= count_q - 5'd1;
    end
  end

  // Flagged one cycle early so the FSM lands in DONE on the same edge the
  // counter reaches zero, keeping latency at exactly 1 + amount.
  assign done = (count_q == 5'd1);
  assign data = data_q;

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Single-request ALU execute unit with valid/ready handshakes on both sides.
// Combinational ops complete one cycle after acceptance; sll runs through a
// serial shifter taking shamt extra cycles. Results are held until taken.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_exec_unit_if slave (request in, result out)
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave bus
);

  alu_state_e state_q, state_d;

  logic                    accept;
  logic                    is_sll;
  logic                    shift_done;
  logic [WIDTH-1:0]        shift_data;
  logic signed [WIDTH-1:0] a_s, b_s, sum_s, diff_s;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_ovf;
  logic [WIDTH-1:0]        result_q;
  logic                    sel_shift_q;
  logic                    overflow_q;
  logic                    illegal_q;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] d);
    return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
  endfunction

  assign accept = bus.in_valid && (state_q == ST_IDLE);
  assign is_sll = (bus.op_code == ALU_SLL);

  assign a_s    = bus.src_a;
  assign b_s    = bus.src_b;
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;

  // Everything except sll resolves combinationally from the live operands
  // and is captured at acceptance; illegal codes fall to result 0.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.op_code)
      ALU_ADD: begin
        alu_res = sum_s;
        alu_ovf = add_ovf(a_s, b_s, sum_s);
      end
      ALU_SUB: begin
        alu_res = diff_s;
        alu_ovf = sub_ovf(a_s, b_s, diff_s);
      end
      ALU_AND: alu_res = a_s & b_s;
      ALU_OR:  alu_res = a_s | b_s;
      ALU_NOR: alu_res = ~(a_s | b_s);
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      default: alu_res = '0;
    endcase
  end

  alu_serial_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept && is_sll),
    .data_in (bus.src_b),
    .amount  (bus.shamt),
    .data    (shift_data),
    .done    (shift_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_sll && (bus.shamt != 5'd0)) state_d = ST_SHIFT;
          else                               state_d = ST_DONE;
        end
      end
      ST_SHIFT: if (shift_done)    state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      sel_shift_q <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (accept) begin
      result_q    <= alu_res;
      sel_shift_q <= is_sll;
      overflow_q  <= alu_ovf;
      illegal_q   <= !is_legal_op(bus.op_code);
    end else if ((state_q == ST_DONE) && bus.out_ready) begin
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end
  end

  // sll results live in the shifter register, which holds still once its
  // counter is exhausted, so no separate copy is kept here.
  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.result     = sel_shift_q ? shift_data : result_q;
  assign bus.zero       = bus.out_valid && (bus.result == '0);
  assign bus.overflow   = overflow_q;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(32)) bus();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Issues one request at the current negedge, scrambles the operands right
  // after acceptance and returns the cycles until out_valid (-1 on timeout).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        output int lat);
    bus.op_code  = op;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.shamt    = sh;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.src_a    = 32'hDEAD_BEEF;
    bus.src_b    = 32'h5A5A_5A5A;
    bus.shamt    = 5'd7;
    bus.op_code  = ALU_SUB;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.zero, bus.overflow, bus.illegal_op} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=10000",
               {bus.in_ready, bus.out_valid, bus.zero, bus.overflow, bus.illegal_op});
    end
    checks++;
    if (bus.result !== 32'h0) begin
      failures++;
      $display("FAIL reset_result got=%h exp=00000000", bus.result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat;
    run_op(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
    checks++;
    if (bus.result !== 32'h8000_0000) begin
      failures++; $display("FAIL add_result got=%h exp=80000000", bus.result);
    end
    checks++;
    if ({bus.overflow, bus.zero, bus.illegal_op} !== 3'b100) begin
      failures++; $display("FAIL add_flags got=%b exp=100", {bus.overflow, bus.zero, bus.illegal_op});
    end
    release_result();
    checks++;
    if ({bus.out_valid, bus.overflow, bus.in_ready} !== 3'b001) begin
      failures++; $display("FAIL add_release got=%b exp=001", {bus.out_valid, bus.overflow, bus.in_ready});
    end
  endtask

  task automatic test_sub();
    int lat;
    run_op(ALU_SUB, 32'd5, 32'd5, 5'd0, lat);
    checks++;
    if ({bus.result, bus.zero, bus.overflow} !== {32'h0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL sub_zero got=%h/%b%b exp=00000000/10", bus.result, bus.zero, bus.overflow);
    end
    release_result();
    run_op(ALU_SUB, 32'h8000_0000, 32'h0000_0001, 5'd0, lat);
    checks++;
    if ({bus.result, bus.overflow, bus.zero} !== {32'h7FFF_FFFF, 1'b1, 1'b0}) begin
      failures++; $display("FAIL sub_ovf got=%h/%b%b exp=7fffffff/10", bus.result, bus.overflow, bus.zero);
    end
    release_result();
  endtask

  task automatic test_slt();
    int lat;
    run_op(ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, lat);
    checks++;
    if ({bus.result, bus.overflow} !== {32'h1, 1'b0}) begin
      failures++; $display("FAIL slt_neg got=%h/%b exp=00000001/0", bus.result, bus.overflow);
    end
    release_result();
    run_op(ALU_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, lat);
    checks++;
    if ({bus.result, bus.zero} !== {32'h0, 1'b1}) begin
      failures++; $display("FAIL slt_pos got=%h/%b exp=00000000/1", bus.result, bus.zero);
    end
    release_result();
  endtask

  task automatic test_logic();
    int lat;
    run_op(ALU_AND, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0, lat);
    checks++;
    if (bus.result !== 32'h00F0_F000) begin
      failures++; $display("FAIL and_result got=%h exp=00f0f000", bus.result);
    end
    release_result();
    run_op(ALU_OR, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0, lat);
    checks++;
    if (bus.result !== 32'hFFF0_FFF0) begin
      failures++; $display("FAIL or_result got=%h exp=fff0fff0", bus.result);
    end
    release_result();
    run_op(ALU_NOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd0, lat);
    checks++;
    if ({bus.result, bus.zero} !== {32'h0, 1'b1}) begin
      failures++; $display("FAIL nor_result got=%h/%b exp=00000000/1", bus.result, bus.zero);
    end
    release_result();
  endtask

  task automatic test_sll();
    int lat;
    run_op(ALU_SLL, 32'h0, 32'h0000_0001, 5'd31, lat);
    checks++;
    if (lat !== 32) begin failures++; $display("FAIL sll31_latency got=%0d exp=32", lat); end
    checks++;
    if ({bus.result, bus.zero, bus.overflow} !== {32'h8000_0000, 1'b0, 1'b0}) begin
      failures++; $display("FAIL sll31_result got=%h/%b%b exp=80000000/00", bus.result, bus.zero, bus.overflow);
    end
    release_result();
    run_op(ALU_SLL, 32'h0, 32'h0000_1234, 5'd0, lat);
    checks++;
    if ({lat == 1, bus.result} !== {1'b1, 32'h0000_1234}) begin
      failures++; $display("FAIL sll0 got=lat %0d res %h exp=lat 1 res 00001234", lat, bus.result);
    end
    release_result();
    run_op(ALU_SLL, 32'h0, 32'h8000_00F1, 5'd4, lat);
    checks++;
    if ({lat == 5, bus.result} !== {1'b1, 32'h0000_0F10}) begin
      failures++; $display("FAIL sll4 got=lat %0d res %h exp=lat 5 res 00000f10", lat, bus.result);
    end
    release_result();
  endtask

  task automatic test_illegal();
    int lat;
    run_op(4'b0101, 32'h1234_5678, 32'h1111_1111, 5'd0, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
    checks++;
    if ({bus.result, bus.illegal_op, bus.zero, bus.overflow} !== {32'h0, 3'b110}) begin
      failures++;
      $display("FAIL illegal_out got=%h/%b%b%b exp=00000000/110",
               bus.result, bus.illegal_op, bus.zero, bus.overflow);
    end
    release_result();
    checks++;
    if (bus.illegal_op !== 1'b0) begin
      failures++; $display("FAIL illegal_clear got=%b exp=0", bus.illegal_op);
    end
  endtask

  task automatic test_hold_done();
    int lat;
    run_op(ALU_ADD, 32'd3, 32'd4, 5'd0, lat);
    bus.op_code  = ALU_ADD;
    bus.src_a    = 32'd20;
    bus.src_b    = 32'd22;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.result} !== {2'b10, 32'd7}) begin
        failures++;
        $display("FAIL hold_cycle%0d got=%b%b/%h exp=10/00000007", i, bus.out_valid, bus.in_ready, bus.result);
      end
    end
    release_result();
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      failures++; $display("FAIL hold_idle got=%b exp=01", {bus.out_valid, bus.in_ready});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.result} !== {1'b1, 32'd42}) begin
      failures++; $display("FAIL hold_second got=%b/%h exp=1/0000002a", bus.out_valid, bus.result);
    end
    release_result();
  endtask

  task automatic test_reset_mid_shift();
    int  lat;
    logic seen;
    bus.op_code  = ALU_SLL;
    bus.src_a    = 32'h0;
    bus.src_b    = 32'h0000_0001;
    bus.shamt    = 5'd20;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
      failures++; $display("FAIL shift_busy got=%b exp=00", {bus.out_valid, bus.in_ready});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.result} !== {2'b10, 32'h0}) begin
      failures++;
      $display("FAIL midshift_reset got=%b%b/%h exp=10/00000000", bus.in_ready, bus.out_valid, bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL abandoned_output got=%b exp=0", seen); end
    run_op(ALU_ADD, 32'd2, 32'd3, 5'd0, lat);
    checks++;
    if ({lat == 1, bus.result} !== {1'b1, 32'd5}) begin
      failures++; $display("FAIL post_reset_add got=lat %0d res %h exp=lat 1 res 00000005", lat, bus.result);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(ALU_SLL, 32'h0, 32'h0000_0003, 5'd2, lat);
    checks++;
    if ({lat == 3, bus.result} !== {1'b1, 32'd12}) begin
      failures++; $display("FAIL b2b_sll got=lat %0d res %h exp=lat 3 res 0000000c", lat, bus.result);
    end
    release_result();
    run_op(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, lat);
    checks++;
    if ({lat == 1, bus.result, bus.zero, bus.overflow} !== {1'b1, 32'h0, 2'b10}) begin
      failures++;
      $display("FAIL b2b_add got=lat %0d res %h z%b o%b exp=lat 1 res 00000000 z1 o0",
               lat, bus.result, bus.zero, bus.overflow);
    end
    release_result();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_code   = 4'b0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.shamt     = '0;
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_sll();
    test_illegal();
    test_hold_done();
    test_reset_mid_shift();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
